// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter that lets two requesters share one SPI master, holding configuration stable around enable.
// Optional build macro SPI_ARB_TIMEOUT_EN adds a TIMEOUT_W-bit RUN watchdog (abort with err and rx_data = 8'hFF).
module spi_arb #(
  parameter int TIMEOUT_W = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  input  logic [1:0] req0_mode,
  input  logic [1:0] req1_mode,
  input  logic [7:0] req0_br,
  input  logic [7:0] req1_br,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rx_data,
  output logic       err,
  output logic       busy,
  output logic [7:0] m_data,
  output logic [7:0] m_spcon,
  output logic [7:0] m_spibr,
  input  logic       m_done,
  input  logic [7:0] m_rxdata,
  output logic [1:0] dbg_state_o
);

  // Handshake: reqN is a level request sampled only in IDLE; the requester keeps it high until it
  // sees its one-cycle doneN. m_done/m_rxdata are a single-cycle strobe honoured only in RUN.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       sel_q, sel_d;
  logic       gnt;
  logic       fin;
  logic [7:0] fin_rx;
  logic [7:0] m_data_q, m_data_d;
  logic [7:0] m_spibr_q, m_spibr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [2:0] spcon_q, spcon_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       busy_q, busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
  logic                 err_q, err_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    m_data_d  = m_data_q;
    m_spibr_d = m_spibr_q;
    spcon_d   = spcon_q;
    rx_data_d = rx_data_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    fin       = 1'b0;
    fin_rx    = m_rxdata;
`ifdef SPI_ARB_TIMEOUT_EN
    err_d     = 1'b0;
    cnt_d     = cnt_q;
`endif
    // ptr_q = 0 favours requester 0 when both request.
    gnt = (req0 & req1) ? ptr_q : req1;

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          sel_d     = gnt;
          m_data_d  = gnt ? req1_data : req0_data;
          m_spibr_d = gnt ? req1_br : req0_br;
          spcon_d   = {(gnt ? req1_mode : req0_mode), 1'b0};
          state_d   = LOAD;
        end
      end
      LOAD: begin
        spcon_d[0] = 1'b1;
        state_d    = RUN;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end
      RUN: begin
        if (m_done) begin
          fin = 1'b1;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt_inc == '1) begin
          fin    = 1'b1;
          fin_rx = 8'hFF;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d    = DONE;
      spcon_d[0] = 1'b0;
      rx_data_d  = fin_rx;
      done0_d    = ~sel_q;
      done1_d    = sel_q;
      ptr_d      = ~sel_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      sel_q     <= 1'b0;
      m_data_q  <= '0;
      m_spibr_q <= '0;
      spcon_q   <= '0;
      rx_data_q <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      m_data_q  <= m_data_d;
      m_spibr_q <= m_spibr_d;
      spcon_q   <= spcon_d;
      rx_data_q <= rx_data_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rx_data     = rx_data_q;
  assign busy        = busy_q;
  assign m_data      = m_data_q;
  assign m_spibr     = m_spibr_q;
  assign m_spcon     = {5'b00000, spcon_q};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: table of single transfers plus hand-written round-robin, stability, reset-abort and watchdog sequences.
module tb_spi_arb;
  localparam int TW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic [1:0] req0_mode = '0, req1_mode = '0;
  logic [7:0] req0_br = '0, req1_br = '0;
  logic       done0, done1, err, busy;
  logic [7:0] rx_data, m_data, m_spcon, m_spibr;
  logic       m_done = 1'b0;
  logic [7:0] m_rxdata = '0;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_arb #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .req0_br(req0_br), .req1_br(req1_br),
    .done0(done0), .done1(done1), .rx_data(rx_data), .err(err), .busy(busy),
    .m_data(m_data), .m_spcon(m_spcon), .m_spibr(m_spibr),
    .m_done(m_done), .m_rxdata(m_rxdata), .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic [1:0] md0, md1;
    logic [7:0] br0, br1;
    logic [7:0] rx;
    int         wait_cyc;
    logic       exp_gnt;
    logic [7:0] exp_spcon;
  } vec_t;

  vec_t vecs[6];

  // One complete transfer; requests are dropped once LOAD is observed.
  task automatic run_xfer(input vec_t v);
    logic [7:0] ed, eb, held;
    ed = v.exp_gnt ? v.d1 : v.d0;
    eb = v.exp_gnt ? v.br1 : v.br0;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1;
    req0_data = v.d0; req1_data = v.d1;
    req0_mode = v.md0; req1_mode = v.md1;
    req0_br = v.br0; req1_br = v.br1;
    @(negedge clk);
    check("load_busy", busy, 1'b1);
    check("load_m_data", m_data, ed);
    check("load_m_spibr", m_spibr, eb);
    check("load_m_spcon", m_spcon, v.exp_spcon);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("run_m_spcon", m_spcon, v.exp_spcon | 8'h01);
    for (int i = 0; i < v.wait_cyc; i++) begin
      @(negedge clk);
      check("run_hold_spcon", m_spcon, v.exp_spcon | 8'h01);
      check("run_no_done", {done0, done1}, 2'b00);
    end
    m_done = 1'b1; m_rxdata = v.rx;
    exp_q.push_back(v.rx);
    @(negedge clk);
    m_done = 1'b0; m_rxdata = 8'h00;
    held = exp_q.pop_front();
    check("done0", done0, !v.exp_gnt);
    check("done1", done1, v.exp_gnt);
    check("done_rx_data", rx_data, held);
    check("done_m_spcon", m_spcon, v.exp_spcon);
    check("done_err", err, 1'b0);
    @(negedge clk);
    check("idle_done", {done0, done1}, 2'b00);
    check("idle_busy", busy, 1'b0);
    check("idle_rx_held", rx_data, held);
  endtask

  initial begin
    //           r0    r1    d0     d1     md0    md1    br0    br1    rx     wt gnt   spcon
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h77, 2'b10, 2'b00, 8'd3,  8'd9,  8'h3C, 2, 1'b0, 8'h04};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h5A, 2'b00, 2'b01, 8'd0,  8'd7,  8'hC3, 0, 1'b1, 8'h02};
    vecs[2] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 2'b11, 2'b00, 8'd1,  8'd2,  8'h81, 1, 1'b0, 8'h06};
    vecs[3] = '{1'b1, 1'b1, 8'h12, 8'h34, 2'b00, 2'b10, 8'd4,  8'd5,  8'h7E, 3, 1'b1, 8'h04};
    vecs[4] = '{1'b1, 1'b1, 8'h66, 8'h99, 2'b01, 2'b11, 8'd8,  8'hFF, 8'h00, 0, 1'b0, 8'h02};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 2'b00, 2'b00, 8'd0,  8'd0,  8'hFF, 1, 1'b0, 8'h00};

    // Reset state while rst_n is held low.
    #12;
    check("rst_m_spcon", m_spcon, 8'h00);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_spibr", m_spibr, 8'h00);
    check("rst_outs", {done0, done1, err, busy}, 4'b0000);
    check("rst_rx_data", rx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters held from the first cycle after reset: grants alternate 0,1,0,1.
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    req0_data = 8'h10; req1_data = 8'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_load_m_data", m_data, (k % 2 == 0) ? 8'h10 : 8'h20);
      @(negedge clk);
      check("rr_run_en", m_spcon[0], 1'b1);
      m_done = 1'b1; m_rxdata = 8'(k + 1);
      exp_q.push_back(8'(k + 1));
      @(negedge clk);
      m_done = 1'b0;
      check("rr_done", {done0, done1}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check("rr_rx_data", rx_data, exp_q.pop_front());
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      @(negedge clk);
      check("rr_single_pulse", {done0, done1}, 2'b00);
    end

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // Request data changes during RUN must not reach the master.
    @(negedge clk);
    req1 = 1'b1; req1_data = 8'h11; req1_mode = 2'b01; req1_br = 8'd6;
    @(negedge clk);
    check("stab_load_m_data", m_data, 8'h11);
    @(negedge clk);
    req1_data = 8'h22; req1_mode = 2'b10; req1_br = 8'h99; req0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stab_m_data", m_data, 8'h11);
      check("stab_m_spibr", m_spibr, 8'd6);
      check("stab_m_spcon", m_spcon, 8'h03);
    end
    m_done = 1'b1; m_rxdata = 8'h5E;
    @(negedge clk);
    m_done = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    check("stab_done1", {done0, done1}, 2'b01);
    check("stab_rx_data", rx_data, 8'h5E);
    check("stab_done_m_data", m_data, 8'h11);

    // m_done outside RUN is ignored.
    @(negedge clk);
    m_done = 1'b1; m_rxdata = 8'hEE;
    @(negedge clk);
    m_done = 1'b0;
    check("ign_done", {done0, done1}, 2'b00);
    check("ign_rx_data", rx_data, 8'h5E);
    check("ign_busy", busy, 1'b0);

    // Serve requester 0 so the pointer favours 1, then abort a transfer with reset.
    run_xfer(vecs[0]);
    @(negedge clk);
    req1 = 1'b1; req1_data = 8'hB7; req1_mode = 2'b11;
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    check("abort_pre_en", m_spcon, 8'h07);
    #2 rst_n = 1'b0;
    #1;
    check("abort_m_spcon", m_spcon, 8'h00);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    check("abort_no_done", {done0, done1}, 2'b00);
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; req0_data = 8'hC0; req1_data = 8'hC1; req0_mode = 2'b00;
    @(negedge clk);
    check("abort_ptr_req0", m_data, 8'hC0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    m_done = 1'b1; m_rxdata = 8'h44;
    @(negedge clk);
    m_done = 1'b0;
    check("abort_after_done0", {done0, done1}, 2'b10);
    check("abort_after_rx", rx_data, 8'h44);
    @(negedge clk);

    // Transfer with no m_done: watchdog abort, or indefinite wait when the watchdog is absent.
    @(negedge clk);
    req0 = 1'b1; req0_data = 8'h3A;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    check("to_run_en", m_spcon[0], 1'b1);
`ifdef SPI_ARB_TIMEOUT_EN
    repeat ((2 ** TW) - 2) begin
      @(negedge clk);
      check("to_wait_no_done", {done0, done1, err}, 3'b000);
    end
    @(negedge clk);
    check("to_done_err", {done0, done1, err}, 3'b101);
    check("to_rx_ff", rx_data, 8'hFF);
    check("to_spcon_off", m_spcon[0], 1'b0);
    @(negedge clk);
    check("to_err_pulse", {err, busy}, 2'b00);
`else
    begin
      int pulses = 0;
      repeat (40) begin
        @(negedge clk);
        if (done0 || done1 || err) pulses++;
      end
      check("nto_no_done", pulses, 0);
    end
    check("nto_busy", busy, 1'b1);
    check("nto_en", m_spcon[0], 1'b1);
    m_done = 1'b1; m_rxdata = 8'h9C;
    @(negedge clk);
    m_done = 1'b0;
    check("nto_done0", {done0, done1, err}, 3'b100);
    check("nto_rx", rx_data, 8'h9C);
    @(negedge clk);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
